// File: rtl/clkgen_multi.sv
// rtl/clkgen_multi.sv - multi-channel programmable clock/strobe generator
//
// Derives NUM_CH independent divided clocks from sysclk. Each channel has a
// runtime-programmable period P and high time H, a run enable, a wrap tick
// and responds to a global phase-align (sync) pulse. Each period is low for
// P-H cycles, then high for H cycles. P<2 acts as 2 and H>P acts as P.
//
// Optional feature macro: CLKGEN_SYNC_RELOAD_EN
//   defined   - writes go to a per-channel shadow and are applied only at the
//               wrap point, while the channel is disabled, or on sync, so no
//               high or low phase is ever truncated.
//   undefined - a write loads the active config at once and restarts the
//               channel counter (the current period may be cut short).
//
// Ports:
//   sysclk      in   1       system clock, all logic on its rising edge
//   reset       in   1       synchronous active-high reset
//   ch_en       in   NUM_CH  per-channel run enable
//   sync        in   1       restarts every enabled channel at count 0
//   cfg_we      in   1       config write strobe
//   cfg_ch      in   CH_W    target channel (>= NUM_CH is ignored)
//   cfg_period  in   CNT_W   period P in sysclk cycles
//   cfg_high    in   CNT_W   high time H in sysclk cycles
//   clk_div     out  NUM_CH  divided clocks, registered
//   tick        out  NUM_CH  one-cycle pulse on every wrap, registered
module clkgen_multi #(
    parameter int CLOCK_FREQ   = 20_000_000,
    parameter int DEFAULT_FREQ = 17,
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(CLOCK_FREQ / DEFAULT_FREQ);
    localparam logic [CNT_W-1:0] DEF_H = DEF_P >> 1;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
        return (p < TWO) ? TWO : p;
    endfunction

    // Length of the low phase after clamping; clk_div is high once the
    // counter has reached it.
    function automatic logic [CNT_W-1:0] low_len(input logic [CNT_W-1:0] p,
                                                 input logic [CNT_W-1:0] h);
        logic [CNT_W-1:0] pe;
        logic [CNT_W-1:0] he;
        pe = eff_period(p);
        he = (h > pe) ? pe : h;
        return pe - he;
    endfunction

    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [CNT_W-1:0]  act_p_q [NUM_CH];
    logic [CNT_W-1:0]  act_p_d [NUM_CH];
    logic [CNT_W-1:0]  act_h_q [NUM_CH];
    logic [CNT_W-1:0]  act_h_d [NUM_CH];
`ifdef CLKGEN_SYNC_RELOAD_EN
    logic [CNT_W-1:0]  shd_p_q [NUM_CH];
    logic [CNT_W-1:0]  shd_p_d [NUM_CH];
    logic [CNT_W-1:0]  shd_h_q [NUM_CH];
    logic [CNT_W-1:0]  shd_h_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
`endif
    logic [NUM_CH-1:0] clk_div_q;
    logic [NUM_CH-1:0] clk_div_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] at_wrap;

    // Write decode and wrap detection. An out-of-range cfg_ch matches no
    // channel index, so such writes fall through untouched.
    always_comb begin
        wr_hit  = '0;
        at_wrap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]  = cfg_we && (cfg_ch == CH_W'(i));
            at_wrap[i] = (cnt_q[i] >= eff_period(act_p_q[i]) - ONE);
        end
    end

    always_comb begin
        clk_div_d = '0;
        tick_d    = '0;
`ifdef CLKGEN_SYNC_RELOAD_EN
        pend_d    = pend_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]   = cnt_q[i];
            act_p_d[i] = act_p_q[i];
            act_h_d[i] = act_h_q[i];
`ifdef CLKGEN_SYNC_RELOAD_EN
            shd_p_d[i] = shd_p_q[i];
            shd_h_d[i] = shd_h_q[i];
            if (!ch_en[i] || sync) begin
                // Idle or re-phasing: the pending shadow takes effect now; a
                // write in this same cycle only lands in the shadow.
                if (pend_q[i]) begin
                    act_p_d[i] = shd_p_q[i];
                    act_h_d[i] = shd_h_q[i];
                    pend_d[i]  = 1'b0;
                end
                cnt_d[i] = '0;
                if (wr_hit[i]) begin
                    shd_p_d[i] = cfg_period;
                    shd_h_d[i] = cfg_high;
                    pend_d[i]  = 1'b1;
                end
            end else if (at_wrap[i]) begin
                // A write arriving in the wrap cycle bypasses the shadow so
                // the very next period already uses it.
                if (wr_hit[i]) begin
                    act_p_d[i] = cfg_period;
                    act_h_d[i] = cfg_high;
                    shd_p_d[i] = cfg_period;
                    shd_h_d[i] = cfg_high;
                    pend_d[i]  = 1'b0;
                end else if (pend_q[i]) begin
                    act_p_d[i] = shd_p_q[i];
                    act_h_d[i] = shd_h_q[i];
                    pend_d[i]  = 1'b0;
                end
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
                if (wr_hit[i]) begin
                    shd_p_d[i] = cfg_period;
                    shd_h_d[i] = cfg_high;
                    pend_d[i]  = 1'b1;
                end
            end
`else
            if (wr_hit[i]) begin
                // Immediate load restarts the period; this is a restart,
                // not a wrap, so no tick.
                act_p_d[i] = cfg_period;
                act_h_d[i] = cfg_high;
                cnt_d[i]   = '0;
            end else if (!ch_en[i] || sync) begin
                cnt_d[i] = '0;
            end else if (at_wrap[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
`endif
            tick_d[i]    = tick_d[i] && ch_en[i];
            clk_div_d[i] = ch_en[i] && (cnt_d[i] >= low_len(act_p_d[i], act_h_d[i]));
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                act_p_q[i] <= DEF_P;
                act_h_q[i] <= DEF_H;
`ifdef CLKGEN_SYNC_RELOAD_EN
                shd_p_q[i] <= DEF_P;
                shd_h_q[i] <= DEF_H;
`endif
            end
`ifdef CLKGEN_SYNC_RELOAD_EN
            pend_q    <= '0;
`endif
            clk_div_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                act_p_q[i] <= act_p_d[i];
                act_h_q[i] <= act_h_d[i];
`ifdef CLKGEN_SYNC_RELOAD_EN
                shd_p_q[i] <= shd_p_d[i];
                shd_h_q[i] <= shd_h_d[i];
`endif
            end
`ifdef CLKGEN_SYNC_RELOAD_EN
            pend_q    <= pend_d;
`endif
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_div = clk_div_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// tb/tb_clkgen_multi.sv - self-checking bench for clkgen_multi
module tb_clkgen_multi;

    localparam int NCH   = 3;
    localparam int CW    = 16;
    localparam int DEF_P = 100;
    localparam int DEF_H = 50;

    logic           sysclk = 1'b0;
    logic           reset;
    logic [NCH-1:0] ch_en;
    logic           sync;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_period;
    logic [CW-1:0]  cfg_high;
    logic [NCH-1:0] clk_div;
    logic [NCH-1:0] tick;

    clkgen_multi #(
        .CLOCK_FREQ   (1000),
        .DEFAULT_FREQ (10),
        .NUM_CH       (NCH),
        .CNT_W        (CW)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .ch_en      (ch_en),
        .sync       (sync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .clk_div    (clk_div),
        .tick       (tick)
    );

    always #5 sysclk = ~sysclk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: each channel's phase is kept as the edge number at
    // which its count was last 0; the count at any edge is then the elapsed
    // edges modulo the effective period.
    int             m_e = 0;
    int             m_start [NCH];
    int             m_ap [NCH];
    int             m_ah [NCH];
    int             m_sp [NCH];
    int             m_sh [NCH];
    bit             m_pend [NCH];
    logic [NCH-1:0] m_clk = '0;
    logic [NCH-1:0] m_tick = '0;

    function automatic int effp(int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic void model_step();
        int  pe, he, cb, ca, cp, chh;
        bit  wr, tk;
        m_e++;
        cp  = int'(cfg_period);
        chh = int'(cfg_high);
        for (int ch = 0; ch < NCH; ch++) begin
            wr = cfg_we && (int'(cfg_ch) == ch);
            if (reset) begin
                m_ap[ch] = DEF_P; m_ah[ch] = DEF_H;
                m_sp[ch] = DEF_P; m_sh[ch] = DEF_H;
                m_pend[ch] = 1'b0;
                m_start[ch] = m_e;
                m_clk[ch] = 1'b0;
                m_tick[ch] = 1'b0;
                continue;
            end
            pe = effp(m_ap[ch]);
            cb = (m_e - 1 - m_start[ch]) % pe;
            tk = 1'b0;
`ifdef CLKGEN_SYNC_RELOAD_EN
            if (!ch_en[ch] || sync) begin
                if (m_pend[ch]) begin
                    m_ap[ch] = m_sp[ch]; m_ah[ch] = m_sh[ch]; m_pend[ch] = 1'b0;
                end
                m_start[ch] = m_e;
                if (wr) begin
                    m_sp[ch] = cp; m_sh[ch] = chh; m_pend[ch] = 1'b1;
                end
            end else if (cb == pe - 1) begin
                if (wr) begin
                    m_ap[ch] = cp; m_ah[ch] = chh;
                    m_sp[ch] = cp; m_sh[ch] = chh; m_pend[ch] = 1'b0;
                end else if (m_pend[ch]) begin
                    m_ap[ch] = m_sp[ch]; m_ah[ch] = m_sh[ch]; m_pend[ch] = 1'b0;
                end
                m_start[ch] = m_e;
                tk = 1'b1;
            end else if (wr) begin
                m_sp[ch] = cp; m_sh[ch] = chh; m_pend[ch] = 1'b1;
            end
`else
            if (wr) begin
                m_ap[ch] = cp; m_ah[ch] = chh;
                m_start[ch] = m_e;
            end else if (!ch_en[ch] || sync) begin
                m_start[ch] = m_e;
            end else if (cb == pe - 1) begin
                tk = 1'b1;
            end
`endif
            pe = effp(m_ap[ch]);
            he = (m_ah[ch] > pe) ? pe : m_ah[ch];
            ca = (m_e - m_start[ch]) % pe;
            m_clk[ch]  = ch_en[ch] && (ca >= pe - he);
            m_tick[ch] = ch_en[ch] && tk;
        end
    endfunction

    task automatic cycle();
        @(posedge sysclk);
        model_step();
        #1;
        chk("model clk_div", int'(clk_div), int'(m_clk));
        chk("model tick", int'(tick), int'(m_tick));
    endtask

    task automatic wr_cfg(input int ch, input int p, input int h);
        cfg_we = 1'b1; cfg_ch = 2'(ch);
        cfg_period = CW'(p); cfg_high = CW'(h);
        cycle();
        cfg_we = 1'b0;
    endtask

    // Write while every channel is idle, then one idle cycle so the value is
    // active in either reload mode before the channel is enabled.
    task automatic prep(input int ch, input int p, input int h);
        ch_en = '0;
        wr_cfg(ch, p, h);
        cycle();
    endtask

    // Enable one channel for n edges and tally its outputs.
    task automatic run_count(input int ch, input int n, output int highs,
                             output int ticks, output int first_high);
        highs = 0; ticks = 0; first_high = 0;
        ch_en = '0;
        ch_en[ch] = 1'b1;
        for (int k = 1; k <= n; k++) begin
            cycle();
            if (clk_div[ch]) begin
                highs++;
                if (first_high == 0) first_high = k;
            end
            if (tick[ch]) ticks++;
        end
        ch_en = '0;
        cycle();
    endtask

    typedef struct {
        logic [2:0] en;
        logic       sy;
        logic       we;
        logic [1:0] ch;
        int         p;
        int         h;
        logic [2:0] eclk;
        logic [2:0] etick;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [2:0] en, logic sy, logic we, logic [1:0] ch,
                                int p, int h, logic [2:0] eclk, logic [2:0] etick);
        vec_t v;
        v.en = en; v.sy = sy; v.we = we; v.ch = ch;
        v.p = p; v.h = h; v.eclk = eclk; v.etick = etick;
        return v;
    endfunction

    initial begin
        int hi, tk, fh, co, first;
        logic [9:0] got_clk, got_tick, exp_clk, exp_tick;

        reset = 1'b1; ch_en = '0; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_high = '0;
        cycle();
        cycle();
        chk("reset clk_div", int'(clk_div), 0);
        chk("reset tick", int'(tick), 0);
        reset = 1'b0;
        cycle();

        // Reset defaults: P=100, H=50.
        run_count(1, 200, hi, tk, fh);
        chk("default highs", hi, 100);
        chk("default ticks", tk, 2);
        chk("default first high", fh, 50);

        // Table: ch0 P=4 H=1, disable mid-high, out-of-range write, sync.
        tbl.push_back(mk(3'b000, 0, 1, 2'd0, 4, 1, 3'b000, 3'b000));
        tbl.push_back(mk(3'b000, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b001, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b001));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b001, 3'b000));
        tbl.push_back(mk(3'b000, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 1, 2'd3, 2, 1, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b001, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b001));
        tbl.push_back(mk(3'b001, 1, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b001, 3'b000));
        tbl.push_back(mk(3'b001, 0, 0, 2'd0, 0, 0, 3'b000, 3'b001));
        for (int v = 0; v < tbl.size(); v++) begin
            ch_en = tbl[v].en; sync = tbl[v].sy; cfg_we = tbl[v].we;
            cfg_ch = tbl[v].ch; cfg_period = CW'(tbl[v].p); cfg_high = CW'(tbl[v].h);
            cycle();
            chk($sformatf("table[%0d] clk_div", v), int'(clk_div), int'(tbl[v].eclk));
            chk($sformatf("table[%0d] tick", v), int'(tick), int'(tbl[v].etick));
        end
        sync = 1'b0; cfg_we = 1'b0; ch_en = '0;
        cycle();

        // P=10 H=3: low 7, high 3, tick every 10.
        prep(0, 10, 3);
        run_count(0, 30, hi, tk, fh);
        chk("p10h3 highs", hi, 9);
        chk("p10h3 ticks", tk, 3);
        chk("p10h3 first high", fh, 7);

        // Edge values.
        prep(0, 5, 0);
        run_count(0, 15, hi, tk, fh);
        chk("h0 highs", hi, 0);
        chk("h0 ticks", tk, 3);
        prep(0, 10, 12);
        run_count(0, 20, hi, tk, fh);
        chk("h>p highs", hi, 20);
        chk("h>p ticks", tk, 2);
        prep(2, 1, 1);
        run_count(2, 10, hi, tk, fh);
        chk("p1 highs", hi, 5);
        chk("p1 ticks", tk, 5);

`ifdef CLKGEN_SYNC_RELOAD_EN
        // ch1 P=8 H=4, write P=4 H=1 while c=2: old period completes first.
        prep(1, 8, 4);
        ch_en = 3'b010;
        cycle();
        cycle();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = CW'(4); cfg_high = CW'(1);
        for (int j = 0; j < 10; j++) begin
            cycle();
            cfg_we = 1'b0;
            got_clk[j]  = clk_div[1];
            got_tick[j] = tick[1];
        end
        exp_clk  = 10'b0100011110;
        exp_tick = 10'b1000100000;
        chk("reload clk pattern", int'(got_clk), int'(exp_clk));
        chk("reload tick pattern", int'(got_tick), int'(exp_tick));
        ch_en = '0;
        cycle();
`endif

        // Phase alignment of ch0 (P=6) and ch2 (P=9).
        prep(0, 6, 2);
        wr_cfg(2, 9, 4);
        cycle();
        ch_en = 3'b001;
        for (int k = 0; k < int'($urandom_range(5)); k++) cycle();
        ch_en = 3'b101;
        for (int k = 0; k < int'($urandom_range(8)) + 1; k++) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        chk("sync clk_div", int'(clk_div), 0);
        chk("sync tick", int'(tick), 0);
        co = 0; first = 0;
        for (int k = 1; k <= 36; k++) begin
            cycle();
            if (tick[0] && tick[2]) begin
                co++;
                if (first == 0) first = k;
            end
        end
        chk("coincide first", first, 18);
        chk("coincide count", co, 2);

        // Reset while a write is outstanding: defaults must be active.
        ch_en = 3'b001;
        cycle();
        wr_cfg(0, 3, 1);
        reset = 1'b1;
        cycle();
        chk("reset mid clk_div", int'(clk_div), 0);
        chk("reset mid tick", int'(tick), 0);
        reset = 1'b0;
        run_count(0, 60, hi, tk, fh);
        chk("post-reset highs", hi, 11);
        chk("post-reset ticks", tk, 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int k;
            if ($urandom_range(15) == 0) begin
                k = int'($urandom_range(NCH - 1));
                ch_en[k] = ~ch_en[k];
            end
            sync       = ($urandom_range(31) == 0);
            cfg_we     = ($urandom_range(3) == 0);
            cfg_ch     = 2'($urandom_range(3));
            cfg_period = CW'($urandom_range(12));
            cfg_high   = CW'($urandom_range(14));
            reset      = ($urandom_range(499) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
